// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data RAM between the CPU MEM stage and an aux master.
// Define DMEM_ARB_FAIR_EN to compile in the wait_cnt fairness override; otherwise the CPU has strict priority.
module dmem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int AUX_MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  input  logic [3:0]        cpu_wstrb_i,
  output logic              cpu_stall_o,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_rvalid_o,
  input  logic              aux_req_i,
  input  logic              aux_we_i,
  input  logic [ADDR_W-1:0] aux_addr_i,
  input  logic [31:0]       aux_wdata_i,
  input  logic [3:0]        aux_wstrb_i,
  output logic              aux_gnt_o,
  output logic [31:0]       aux_rdata_o,
  output logic              aux_rvalid_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  typedef enum logic [1:0] {
    RD_NONE,
    RD_CPU,
    RD_AUX
  } rd_state_t;

  rd_state_t rd_state, rd_next;
  logic      cpu_gnt;
  logic      aux_gnt;
  logic      fair_force;

  if (AUX_MAX_WAIT < 1 || AUX_MAX_WAIT > 255) begin : g_bad_aux_max_wait
    $error("dmem_arbiter: AUX_MAX_WAIT must be in 1..255");
  end

`ifdef DMEM_ARB_FAIR_EN
  logic [7:0] wait_cnt;

  assign fair_force = (wait_cnt == 8'(AUX_MAX_WAIT));

  // Consecutive aux denials; reaching the limit forces aux through next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= 8'd0;
    end else if (!aux_req_i || aux_gnt) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt < 8'(AUX_MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign fair_force = 1'b0;
`endif

  // No grant at all while reset is held, so the RAM is never touched then.
  always_comb begin
    cpu_gnt = 1'b0;
    aux_gnt = 1'b0;
    if (!rst_i) begin
      if (aux_req_i && (!cpu_req_i || fair_force)) begin
        aux_gnt = 1'b1;
      end else if (cpu_req_i) begin
        cpu_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 4'b0000;
    ram_addr_o  = '0;
    ram_wdata_o = 32'd0;
    if (cpu_gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = cpu_we_i ? cpu_wstrb_i : 4'b0000;
      ram_addr_o  = cpu_addr_i;
      ram_wdata_o = cpu_wdata_i;
    end else if (aux_gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = aux_we_i ? aux_wstrb_i : 4'b0000;
      ram_addr_o  = aux_addr_i;
      ram_wdata_o = aux_wdata_i;
    end
  end

  assign cpu_stall_o = cpu_req_i && !cpu_gnt;
  assign aux_gnt_o   = aux_gnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state <= RD_NONE;
    end else begin
      rd_state <= rd_next;
    end
  end

  // Owner of the read data returning next cycle; writes leave it at RD_NONE.
  always_comb begin
    rd_next      = RD_NONE;
    cpu_rvalid_o = 1'b0;
    cpu_rdata_o  = 32'd0;
    aux_rvalid_o = 1'b0;
    aux_rdata_o  = 32'd0;
    if (cpu_gnt && !cpu_we_i) begin
      rd_next = RD_CPU;
    end else if (aux_gnt && !aux_we_i) begin
      rd_next = RD_AUX;
    end
    case (rd_state)
      RD_CPU: begin
        cpu_rvalid_o = 1'b1;
        cpu_rdata_o  = ram_rdata_i;
      end
      RD_AUX: begin
        aux_rvalid_o = 1'b1;
        aux_rdata_o  = ram_rdata_i;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter with a bench-side RAM and a behavioural model.
// The expected arbitration follows DMEM_ARB_FAIR_EN the same way the design does.
module tb_dmem_arbiter;

  localparam int ADDR_W = 14;
  localparam int MAXW   = 4;
`ifdef DMEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [31:0]       cpu_wdata = '0;
  logic [3:0]        cpu_wstrb = '0;
  logic              aux_req = 1'b0, aux_we = 1'b0;
  logic [ADDR_W-1:0] aux_addr = '0;
  logic [31:0]       aux_wdata = '0;
  logic [3:0]        aux_wstrb = '0;
  logic              cpu_stall, cpu_rvalid, aux_gnt, aux_rvalid, ram_en;
  logic [31:0]       cpu_rdata, aux_rdata, ram_wdata;
  logic [31:0]       ram_rdata = '0;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Bench RAM (the environment) and the model's own shadow copy.
  logic [31:0] mem    [0:(1<<ADDR_W)-1];
  logic [31:0] shadow [0:(1<<ADDR_W)-1];

  // Model state: consecutive aux denials and the read expected to return next cycle.
  int          denied    = 0;
  int          pend      = 0;
  logic [31:0] pend_data = '0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .AUX_MAX_WAIT(MAXW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_wstrb_i(cpu_wstrb),
    .cpu_stall_o(cpu_stall), .cpu_rdata_o(cpu_rdata), .cpu_rvalid_o(cpu_rvalid),
    .aux_req_i(aux_req), .aux_we_i(aux_we), .aux_addr_i(aux_addr),
    .aux_wdata_i(aux_wdata), .aux_wstrb_i(aux_wstrb),
    .aux_gnt_o(aux_gnt), .aux_rdata_o(aux_rdata), .aux_rvalid_o(aux_rvalid),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model, then advance the model past the coming edge.
  task automatic checkOutput();
    bit          e_aux, e_cpu, e_we;
    logic [3:0]  e_strb;
    logic [31:0] e_addr, e_wdata;
    e_aux = !rst && aux_req && (!cpu_req || (FAIR && denied >= MAXW));
    e_cpu = !rst && cpu_req && !e_aux;
    e_we = 1'b0; e_strb = 4'd0; e_addr = 32'd0; e_wdata = 32'd0;
    if (e_cpu) begin
      e_we = cpu_we; e_strb = cpu_wstrb; e_addr = 32'(cpu_addr); e_wdata = cpu_wdata;
    end else if (e_aux) begin
      e_we = aux_we; e_strb = aux_wstrb; e_addr = 32'(aux_addr); e_wdata = aux_wdata;
    end
    if (rst) pend = 0;
    check("ram_en", 32'(ram_en), 32'(e_cpu || e_aux));
    check("ram_we", 32'(ram_we), e_we ? 32'(e_strb) : 32'd0);
    check("ram_addr", 32'(ram_addr), e_addr);
    check("ram_wdata", ram_wdata, e_wdata);
    check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cpu));
    check("aux_gnt", 32'(aux_gnt), 32'(e_aux));
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(pend == 1));
    check("cpu_rdata", cpu_rdata, (pend == 1) ? pend_data : 32'd0);
    check("aux_rvalid", 32'(aux_rvalid), 32'(pend == 2));
    check("aux_rdata", aux_rdata, (pend == 2) ? pend_data : 32'd0);
    pend = 0;
    if ((e_cpu || e_aux) && !e_we) begin
      pend      = e_cpu ? 1 : 2;
      pend_data = shadow[e_addr];
    end else if (e_cpu || e_aux) begin
      for (int b = 0; b < 4; b++)
        if (e_strb[b]) shadow[e_addr][8*b +: 8] = e_wdata[8*b +: 8];
    end
    if (rst || !aux_req || e_aux) denied = 0;
    else denied++;
  endtask

  task automatic applyStimulus(input bit r,
                               input bit cr, input bit cw, input int ca, input logic [31:0] cd, input logic [3:0] cs,
                               input bit ar, input bit aw, input int aa, input logic [31:0] ad, input logic [3:0] as);
    @(posedge clk);
    #1;
    rst = r;
    cpu_req = cr; cpu_we = cw; cpu_addr = ADDR_W'(ca); cpu_wdata = cd; cpu_wstrb = cs;
    aux_req = ar; aux_we = aw; aux_addr = ADDR_W'(aa); aux_wdata = ad; aux_wstrb = as;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input bit r);
    applyStimulus(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int aux_grants;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i]    = 32'd0;
      shadow[i] = 32'd0;
    end
    mem[16]    = 32'hDEADBEEF;
    shadow[16] = 32'hDEADBEEF;

    $display("[TB] start, fairness override %0d", FAIR);
    idle(1);
    idle(1);
    applyStimulus(1, 1, 0, 16, 0, 0, 1, 0, 32, 0, 0);
    check("reset_stall_lit", 32'(cpu_stall), 32'd1);
    check("reset_ram_en_lit", 32'(ram_en), 32'd0);
    check("reset_aux_gnt_lit", 32'(aux_gnt), 32'd0);
    idle(0);

    applyStimulus(0, 1, 0, 16, 0, 0, 0, 0, 0, 0, 0);
    check("cpu_load_en_lit", 32'(ram_en), 32'd1);
    check("cpu_load_stall_lit", 32'(cpu_stall), 32'd0);
    idle(0);
    check("cpu_load_rvalid_lit", 32'(cpu_rvalid), 32'd1);
    check("cpu_load_data_lit", cpu_rdata, 32'hDEADBEEF);

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32, 32'h12345678, 4'b0011);
    check("aux_store_gnt_lit", 32'(aux_gnt), 32'd1);
    check("aux_store_we_lit", 32'(ram_we), 32'h3);
    idle(0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32, 0, 0);
    idle(0);
    check("aux_load_rvalid_lit", 32'(aux_rvalid), 32'd1);
    check("aux_load_data_lit", aux_rdata, 32'h00005678);

    // Both masters requesting continuously from a cleared wait count.
    aux_grants = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 0, 16, 0, 0, 1, 0, 32, 0, 0);
      if (aux_gnt) aux_grants++;
      if (i == 4) check("contend_5th_gnt_lit", 32'(aux_gnt), FAIR ? 32'd1 : 32'd0);
    end
    check("contend_aux_grants_lit", 32'(aux_grants), FAIR ? 32'd2 : 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32, 0, 0);
    check("cpu_drop_aux_gnt_lit", 32'(aux_gnt), 32'd1);
    idle(0);

    applyStimulus(0, 1, 0, 16, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32, 0, 0);
    check("b2b_cpu_rvalid_lit", 32'(cpu_rvalid), 32'd1);
    check("b2b_cpu_data_lit", cpu_rdata, 32'hDEADBEEF);
    check("b2b_aux_quiet_lit", 32'(aux_rvalid), 32'd0);
    idle(0);
    check("b2b_aux_rvalid_lit", 32'(aux_rvalid), 32'd1);
    check("b2b_aux_data_lit", aux_rdata, 32'h00005678);
    check("b2b_cpu_quiet_lit", 32'(cpu_rvalid), 32'd0);

    applyStimulus(0, 1, 0, 16, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    check("rst_drop_rvalid_lit", 32'(cpu_rvalid), 32'd0);
    idle(0);
    check("post_rst_rvalid_lit", 32'(cpu_rvalid), 32'd0);
    check("post_rst_rdata_lit", cpu_rdata, 32'd0);
    check("post_rst_en_lit", 32'(ram_en), 32'd0);

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 49) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    int'($urandom_range(0, 31)), $urandom, 4'($urandom),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                    int'($urandom_range(0, 31)), $urandom, 4'($urandom));
    end
    idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
